i2c_sensor_poller: RTL

//  Upstream sequencer for the I2C master. It configures the sensor once with a single register

---
 rtl/i2c_sensor_poller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_sensor_poller.sv
// Sequencer in front of an I2C master: one init register write (retried until it succeeds),
// then one burst read per TRIG, with good bursts published on SAMPLE.
module i2c_sensor_poller #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter logic [7:0] INIT_REG = 8'h6B,
  parameter logic [7:0] INIT_VAL = 8'h00,
  parameter logic [7:0] RD_REG   = 8'h3B,
  parameter int         RD_BYTES = 14,
  parameter int         TIMEOUT  = 200000,
  parameter int         GAP      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TRIG,
  output logic [6:0]            I2C_DEVICE_ADDR,
  output logic [7:0]            I2C_REG_ADDR,
  output logic                  I2C_READ_EN,
  output logic [7:0]            I2C_READ_SIZE,
  output logic                  I2C_WRITE_EN,
  output logic [7:0]            I2C_WRITE_DATA,
  input  logic [7:0]            I2C_READ_DATA,
  input  logic                  I2C_READ_VALID,
  input  logic                  I2C_NACK,
  input  logic                  I2C_BUSY,
  output logic [8*RD_BYTES-1:0] SAMPLE,
  output logic                  SAMPLE_VALID,
  output logic                  INIT_DONE,
  output logic [7:0]            ERR_CNT,
  output logic [7:0]            OVR_CNT
);
  localparam int SW = 8 * RD_BYTES;
  localparam int IW = $clog2(RD_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {W_REQ, W_RUN, W_GAP, IDLE, R_REQ, R_RUN, R_GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          nack_q, nack_d, fail_q, fail_d, extra_q, extra_d, rv_prev_q, rv_prev_d;
  logic          wen_q, wen_d, ren_q, ren_d, sample_valid_q, sample_valid_d;
  logic          init_done_q, init_done_d;
  logic [SW-1:0] staging_q, staging_d, sample_q, sample_d;
  logic [7:0]    err_q, err_d, ovr_q, ovr_d;
  logic          err_inc, read_bad, tmo_hit, rv_rise;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
  assign rv_rise = I2C_READ_VALID & ~rv_prev_q;

  always_comb begin
    state_d        = state_q;
    tmo_d          = tmo_q;
    gap_d          = gap_q;
    idx_d          = idx_q;
    nack_d         = nack_q;
    fail_d         = fail_q;
    extra_d        = extra_q;
    rv_prev_d      = I2C_READ_VALID;
    staging_d      = staging_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    init_done_d    = init_done_q;
    err_d          = err_q;
    ovr_d          = ovr_q;
    err_inc        = 1'b0;
    read_bad       = 1'b0;
    if (TRIG && state_q != IDLE && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    case (state_q)
      W_REQ, R_REQ: begin
        if (tmo_hit) begin
          state_d = (state_q == W_REQ) ? W_GAP : R_GAP;
          fail_d  = 1'b1;
          err_inc = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (I2C_BUSY) state_d = (state_q == W_REQ) ? W_RUN : R_RUN;
        end
      end
      W_RUN, R_RUN: begin
        if (I2C_NACK) nack_d = 1'b1;
        // Bytes are shifted in, so after exactly RD_BYTES strobes the first byte sits in the MSBs.
        if (state_q == R_RUN && rv_rise) begin
          if (idx_q == IW'(RD_BYTES)) extra_d = 1'b1;
          else begin
            staging_d = SW'({staging_q, I2C_READ_DATA});
            idx_d     = idx_q + IW'(1);
          end
        end
        if (!I2C_BUSY) begin
          if (state_q == W_RUN) begin
            state_d = W_GAP;
            fail_d  = nack_d;
            err_inc = nack_d;
          end else begin
            state_d  = R_GAP;
            read_bad = nack_d | extra_d | (idx_d != IW'(RD_BYTES));
            err_inc  = read_bad;
            if (!read_bad) begin
              sample_d       = staging_d;
              sample_valid_d = 1'b1;
            end
          end
        end else if (tmo_hit) begin
          state_d = (state_q == W_RUN) ? W_GAP : R_GAP;
          fail_d  = 1'b1;
          err_inc = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      W_GAP, R_GAP: begin
        tmo_d  = '0;
        nack_d = 1'b0;
        if (gap_q == GW'(GAP - 1)) begin
          gap_d = '0;
          if (state_q == R_GAP) state_d = IDLE;
          else if (fail_q) state_d = W_REQ;
          else begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        tmo_d   = '0;
        nack_d  = 1'b0;
        idx_d   = '0;
        extra_d = 1'b0;
        if (TRIG) state_d = R_REQ;
      end
    endcase
    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
    // Enables are registered from the next state so they stay low while reset holds W_REQ.
    wen_d = (state_d == W_REQ) || (state_d == W_RUN);
    ren_d = (state_d == R_REQ) || (state_d == R_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= W_REQ;
      tmo_q          <= '0;
      gap_q          <= '0;
      idx_q          <= '0;
      nack_q         <= 1'b0;
      fail_q         <= 1'b0;
      extra_q        <= 1'b0;
      rv_prev_q      <= 1'b0;
      wen_q          <= 1'b0;
      ren_q          <= 1'b0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      staging_q      <= '0;
      sample_q       <= '0;
      err_q          <= '0;
      ovr_q          <= '0;
    end else begin
      state_q        <= state_d;
      tmo_q          <= tmo_d;
      gap_q          <= gap_d;
      idx_q          <= idx_d;
      nack_q         <= nack_d;
      fail_q         <= fail_d;
      extra_q        <= extra_d;
      rv_prev_q      <= rv_prev_d;
      wen_q          <= wen_d;
      ren_q          <= ren_d;
      sample_valid_q <= sample_valid_d;
      init_done_q    <= init_done_d;
      staging_q      <= staging_d;
      sample_q       <= sample_d;
      err_q          <= err_d;
      ovr_q          <= ovr_d;
    end
  end

  assign I2C_DEVICE_ADDR = DEV_ADDR;
  assign I2C_REG_ADDR    = (state_q == W_REQ || state_q == W_RUN || state_q == W_GAP) ? INIT_REG : RD_REG;
  assign I2C_READ_SIZE   = 8'(RD_BYTES);
  assign I2C_WRITE_DATA  = INIT_VAL;
  assign I2C_WRITE_EN    = wen_q;
  assign I2C_READ_EN     = ren_q;
  assign SAMPLE          = sample_q;
  assign SAMPLE_VALID    = sample_valid_q;
  assign INIT_DONE       = init_done_q;
  assign ERR_CNT         = err_q;
  assign OVR_CNT         = ovr_q;
endmodule
